video_window_src: RTL and testbench

// - Pixel source feeding the HDMI timing driver: answers its data_req with pixel_data one cycle later.
// - Centres the IMG_H x IMG_V camera image (read from the pixel FIFO) inside the DISP_H x DISP_V raster.
// - Fills the surrounding border with BORDER_COLOR; can substitute colour bars when no camera is present.
// - Flags FIFO underflow and resynchronises the FIFO to frame start.

---
 rtl/video_window_src_pkg.sv | 52 +++++
 rtl/video_bar_gen.sv | 35 +++
 rtl/video_window_src.sv | 173 +++++++++++++++++
 tb/tb_video_window_src.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_window_src_pkg.sv
// Shared constants for the video window source: raster/image defaults, RGB565 bar palette,
// FSM and pixel-select encodings.
package video_window_src_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned PIX_W = 16;

    localparam int unsigned DISP_H_DEF = 1024;
    localparam int unsigned DISP_V_DEF = 768;
    localparam int unsigned IMG_H_DEF  = 640;
    localparam int unsigned IMG_V_DEF  = 480;

    localparam logic [PIX_W-1:0] BORDER_DEF  = 16'h0000;

    localparam logic [PIX_W-1:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [PIX_W-1:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [PIX_W-1:0] RGB_CYAN    = 16'h07FF;
    localparam logic [PIX_W-1:0] RGB_GREEN   = 16'h07E0;
    localparam logic [PIX_W-1:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [PIX_W-1:0] RGB_RED     = 16'hF800;
    localparam logic [PIX_W-1:0] RGB_BLUE    = 16'h001F;
    localparam logic [PIX_W-1:0] RGB_BLACK   = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_ACTIVE
    } state_e;

    typedef enum logic [1:0] {
        SEL_BORDER,
        SEL_BAR,
        SEL_FIFO
    } pix_sel_e;

    // Bar index 0..7, left to right.
    function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
        logic [PIX_W-1:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/video_bar_gen.sv
// Colour-bar generator: window-relative column in, registered RGB565 bar colour out one cycle later.
module video_bar_gen
    import video_window_src_pkg::*;
#(
    parameter int unsigned IMG_H = IMG_H_DEF
) (
    input  logic             pixel_clk,
    input  logic             sys_rst_n,
    input  logic [CNT_W-1:0] col_i,
    output logic [PIX_W-1:0] color_o
);

    localparam int unsigned BAR_W = ((IMG_H / 8) > 0) ? (IMG_H / 8) : 1;

    logic [CNT_W-1:0] idx_full;
    logic [2:0]       idx;
    logic [PIX_W-1:0] color_q;

    // Columns past the eighth full bar (IMG_H not a multiple of 8) stay in the last bar.
    always_comb begin
        idx_full = col_i / CNT_W'(BAR_W);
        idx      = (idx_full > CNT_W'(7)) ? 3'd7 : idx_full[2:0];
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            color_q <= RGB_BLACK;
        end else begin
            color_q <= bar_color(idx);
        end
    end

    assign color_o = color_q;

endmodule

// File: rtl/video_window_src.sv
// Pixel source for the HDMI timing driver: centres the camera image in the raster,
// fills the border, optionally substitutes colour bars, and tracks FIFO underflow.
module video_window_src
    import video_window_src_pkg::*;
#(
    parameter int unsigned      DISP_H       = DISP_H_DEF,
    parameter int unsigned      DISP_V       = DISP_V_DEF,
    parameter int unsigned      IMG_H        = IMG_H_DEF,
    parameter int unsigned      IMG_V        = IMG_V_DEF,
    parameter logic [PIX_W-1:0] BORDER_COLOR = BORDER_DEF
) (
    input  logic             pixel_clk,
    input  logic             sys_rst_n,
    input  logic             video_vs_i,
    input  logic             data_req_i,
    input  logic             src_ready_i,
    input  logic             pattern_en_i,
    output logic             fifo_rd_en_o,
    input  logic [PIX_W-1:0] fifo_q_i,
    input  logic             fifo_empty_i,
    output logic             fifo_flush_o,
    output logic [PIX_W-1:0] pixel_data_o,
    output logic             underflow_o
);

    localparam int unsigned H_OFS = (DISP_H - IMG_H) / 2;
    localparam int unsigned V_OFS = (DISP_V - IMG_V) / 2;

    localparam logic [CNT_W-1:0] COL_LO  = CNT_W'(H_OFS);
    localparam logic [CNT_W-1:0] COL_HI  = CNT_W'(H_OFS + IMG_H - 1);
    localparam logic [CNT_W-1:0] ROW_LO  = CNT_W'(V_OFS);
    localparam logic [CNT_W-1:0] ROW_HI  = CNT_W'(V_OFS + IMG_V - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    pix_sel_e         sel_q;
    logic             vs_q;
    logic             req_q;
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic             pattern_q;
    logic             flush_q;
    logic             underflow_q;

    logic             vs_fall_c;
    logic             req_fall_c;
    logic             active_c;
    logic             in_window_c;
    logic             fifo_rd_en_c;
    logic [PIX_W-1:0] bar_color_c;

    assign vs_fall_c    = vs_q & ~video_vs_i;
    assign req_fall_c   = req_q & ~data_req_i;
    assign active_c     = (state_q == ST_ACTIVE);
    assign in_window_c  = (col_q >= COL_LO) && (col_q <= COL_HI) &&
                          (row_q >= ROW_LO) && (row_q <= ROW_HI);
    assign fifo_rd_en_c = active_c & data_req_i & in_window_c & ~pattern_q;

    // Raster position of the current request; saturating, cleared at field start.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (data_req_i) begin
            if (col_q != CNT_MAX) begin
                col_d = col_q + CNT_W'(1);
            end
        end else begin
            col_d = '0;
        end
        if (req_fall_c && (row_q != CNT_MAX)) begin
            row_d = row_q + CNT_W'(1);
        end
        if (vs_fall_c) begin
            col_d = '0;
            row_d = '0;
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q  <= 1'b0;
            req_q <= 1'b0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            vs_q  <= video_vs_i;
            req_q <= data_req_i;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Frame sequencing; losing the source overrides everything, including a coincident field start.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            pattern_q   <= 1'b0;
            flush_q     <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            if (!src_ready_i) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_WAIT_VS;
                    end
                    ST_WAIT_VS: begin
                        if (vs_fall_c) begin
                            state_q     <= ST_ACTIVE;
                            flush_q     <= 1'b1;
                            pattern_q   <= pattern_en_i;
                            underflow_q <= 1'b0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (vs_fall_c) begin
                            flush_q   <= 1'b1;
                            pattern_q <= pattern_en_i;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
            if (fifo_rd_en_c && fifo_empty_i) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // Source choice for the pixel answered in the next cycle.
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_q <= SEL_BORDER;
        end else begin
            sel_q <= SEL_BORDER;
            if (data_req_i && active_c && in_window_c) begin
                if (pattern_q) begin
                    sel_q <= SEL_BAR;
                end else if (!fifo_empty_i) begin
                    sel_q <= SEL_FIFO;
                end
            end
        end
    end

    video_bar_gen #(
        .IMG_H (IMG_H)
    ) u_bar_gen (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .col_i     (col_q - COL_LO),
        .color_o   (bar_color_c)
    );

    // FIFO data arrives the cycle after the read, so the final mux follows the registered select.
    always_comb begin
        pixel_data_o = BORDER_COLOR;
        case (sel_q)
            SEL_BAR:  pixel_data_o = bar_color_c;
            SEL_FIFO: pixel_data_o = fifo_q_i;
            default:  pixel_data_o = BORDER_COLOR;
        endcase
    end

    assign fifo_rd_en_o = fifo_rd_en_c;
    assign fifo_flush_o = flush_q;
    assign underflow_o  = underflow_q;

endmodule

// File: tb/tb_video_window_src.sv
// Randomised raster/FIFO bench for video_window_src against a frame-level reference model.
module tb_video_window_src;

    localparam int unsigned T_DISP_H = 41;
    localparam int unsigned T_DISP_V = 21;
    localparam int unsigned T_IMG_H  = 24;
    localparam int unsigned T_IMG_V  = 10;
    localparam logic [15:0] T_BORDER = 16'h18E3;

    localparam int HOFS   = (T_DISP_H - T_IMG_H) / 2;
    localparam int VOFS   = (T_DISP_V - T_IMG_V) / 2;
    localparam int NPIX   = T_IMG_H * T_IMG_V;
    localparam int BW     = T_IMG_H / 8;
    localparam int VS_LEN = 3;
    localparam int BP     = 4;
    localparam int FP     = 3;

    logic        pixel_clk  = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        video_vs   = 1'b1;
    logic        data_req   = 1'b0;
    logic        src_ready  = 1'b0;
    logic        pattern_en = 1'b0;
    logic        fifo_rd_en;
    logic [15:0] fifo_q     = 16'h0000;
    logic        fifo_empty = 1'b1;
    logic        fifo_flush;
    logic [15:0] pixel_data;
    logic        underflow;

    int          n_vec = 0;
    int          n_err = 0;

    logic [15:0] bars [0:7];
    logic [15:0] fq [$];
    int          rd_cnt = 0;

    logic        plan_pat   = 1'b0;
    logic [31:0] plan_seed  = 32'h0;
    int          plan_limit = 0;

    logic        prev_vs     = 1'b1;
    logic        live        = 1'b0;
    int          run         = 0;
    logic        exp_uf      = 1'b0;
    logic        exp_flush   = 1'b0;
    logic        pend_valid  = 1'b0;
    logic [15:0] pend_pix    = 16'h0;
    logic        frame_pat   = 1'b0;
    logic [31:0] frame_seed  = 32'h0;
    int          frame_limit = 0;

    int          drop_down  = 0;
    int          drop_len_g = 0;
    logic        no_src_g   = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    video_window_src #(
        .DISP_H       (T_DISP_H),
        .DISP_V       (T_DISP_V),
        .IMG_H        (T_IMG_H),
        .IMG_V        (T_IMG_V),
        .BORDER_COLOR (T_BORDER)
    ) dut (
        .pixel_clk    (pixel_clk),
        .sys_rst_n    (sys_rst_n),
        .video_vs_i   (video_vs),
        .data_req_i   (data_req),
        .src_ready_i  (src_ready),
        .pattern_en_i (pattern_en),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_q_i     (fifo_q),
        .fifo_empty_i (fifo_empty),
        .fifo_flush_o (fifo_flush),
        .pixel_data_o (pixel_data),
        .underflow_o  (underflow)
    );

    function automatic logic [15:0] word(input logic [31:0] seed, input int p);
        logic [31:0] h;
        h = seed ^ (32'(p) * 32'h9E3779B1);
        return h[31:16];
    endfunction

    // Non-show-ahead FIFO, refilled with the planned frame contents on every flush.
    always @(posedge pixel_clk) begin
        if (fifo_flush) begin
            fq.delete();
            for (int i = 0; i < plan_limit; i++) fq.push_back(word(plan_seed, i));
        end else if (fifo_rd_en && (fq.size() > 0)) begin
            fifo_q <= fq.pop_front();
        end
        if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
        fifo_empty <= (fq.size() == 0);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One pixel clock: check last cycle's results, drive this cycle, predict, advance the model.
    task automatic tick(input logic vs, input logic req, input int row, input int col,
                        input logic rdy, input logic pat);
        logic vs_fall;
        logic win;
        logic uf_ev;
        int   p;
        int   bi;
        @(negedge pixel_clk);
        if (pend_valid) check_eq("pixel_data", 32'(pixel_data), 32'(pend_pix));
        check_eq("underflow", 32'(underflow), 32'(exp_uf));
        check_eq("fifo_flush", 32'(fifo_flush), 32'(exp_flush));
        video_vs   = vs;
        data_req   = req;
        src_ready  = rdy;
        pattern_en = pat;
        #1;
        vs_fall = prev_vs && !vs;
        win = req && (col >= HOFS) && (col < HOFS + T_IMG_H) &&
              (row >= VOFS) && (row < VOFS + T_IMG_V);
        check_eq("fifo_rd_en", 32'(fifo_rd_en), 32'(live && win && !frame_pat));
        uf_ev      = 1'b0;
        pend_valid = req;
        pend_pix   = T_BORDER;
        if (live && win) begin
            p = (row - VOFS) * T_IMG_H + (col - HOFS);
            if (frame_pat) begin
                bi = (col - HOFS) / BW;
                if (bi > 7) bi = 7;
                pend_pix = bars[bi];
            end else if (p < frame_limit) begin
                pend_pix = word(frame_seed, p);
            end else begin
                uf_ev = 1'b1;
            end
        end
        exp_flush = 1'b0;
        if (!rdy) begin
            live = 1'b0;
            run  = 0;
        end else begin
            if (vs_fall && (live || run > 0)) begin
                exp_flush   = 1'b1;
                if (!live) exp_uf = 1'b0;
                live        = 1'b1;
                frame_pat   = pat;
                frame_seed  = plan_seed;
                frame_limit = plan_limit;
            end
            run++;
        end
        if (uf_ev) exp_uf = 1'b1;
        prev_vs = vs;
    endtask

    task automatic ftick(input logic vs, input logic req, input int row, input int col,
                         input logic trig, input logic pat);
        logic rdy;
        if (trig) drop_down = drop_len_g;
        rdy = !no_src_g && (drop_down == 0);
        if (drop_down > 0) drop_down--;
        tick(vs, req, row, col, rdy, pat);
    endtask

    // drop_row -1: source lost together with the field sync; -2: no drop.
    task automatic run_frame(input int drop_row, input int drop_col, input int drop_len,
                             input logic no_src);
        int hb;
        drop_len_g = drop_len;
        no_src_g   = no_src;
        drop_down  = 0;
        for (int i = 0; i < VS_LEN; i++)
            ftick(1'b0, 1'b0, 0, 0, (drop_row == -1) && (i == 0), plan_pat);
        for (int i = 0; i < BP; i++)
            ftick(1'b1, 1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
        for (int r = 0; r < T_DISP_V; r++) begin
            for (int c = 0; c < T_DISP_H; c++)
                ftick(1'b1, 1'b1, r, c, (r == drop_row) && (c == drop_col),
                      1'($urandom_range(0, 1)));
            hb = $urandom_range(2, 5);
            for (int i = 0; i < hb; i++)
                ftick(1'b1, 1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < FP; i++)
            ftick(1'b1, 1'b0, 0, 0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic set_plan(input logic pat, input int limit);
        plan_pat   = pat;
        plan_seed  = $urandom;
        plan_limit = limit;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_pixel_data", 32'(pixel_data), 32'(T_BORDER));
        check_eq("rst_underflow", 32'(underflow), 32'(0));
        check_eq("rst_fifo_flush", 32'(fifo_flush), 32'(0));
        check_eq("rst_fifo_rd_en", 32'(fifo_rd_en), 32'(0));
    endtask

    initial begin
        int rd0;
        int dr;
        bars[0] = 16'hFFFF; bars[1] = 16'hFFE0; bars[2] = 16'h07FF; bars[3] = 16'h07E0;
        bars[4] = 16'hF81F; bars[5] = 16'hF800; bars[6] = 16'h001F; bars[7] = 16'h0000;

        repeat (3) @(negedge pixel_clk);
        #1;
        check_reset_outputs();
        sys_rst_n = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

        // No source for a whole field: border only, no reads, no flush.
        set_plan(1'b0, NPIX);
        rd0 = rd_cnt;
        run_frame(-2, 0, 0, 1'b1);
        check_eq("rd_no_source", 32'(rd_cnt - rd0), 32'(0));
        repeat (3) tick(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);

        // Camera, full FIFO: one read per window pixel.
        set_plan(1'b0, NPIX);
        rd0 = rd_cnt;
        run_frame(-2, 0, 0, 1'b0);
        check_eq("rd_per_frame", 32'(rd_cnt - rd0), 32'(NPIX));

        // Colour bars: no reads.
        set_plan(1'b1, NPIX);
        rd0 = rd_cnt;
        run_frame(-2, 0, 0, 1'b0);
        check_eq("rd_pattern", 32'(rd_cnt - rd0), 32'(0));

        // FIFO runs dry mid-frame, then a full frame while underflow stays sticky.
        set_plan(1'b0, $urandom_range(30, NPIX - 30));
        run_frame(-2, 0, 0, 1'b0);
        set_plan(1'b0, NPIX);
        run_frame(-2, 0, 0, 1'b0);

        // Source lost mid-line inside the window, then resync on the next field.
        set_plan(1'b0, NPIX);
        run_frame(VOFS + 3, HOFS + 5, 6, 1'b0);
        set_plan(1'b0, NPIX);
        run_frame(-2, 0, 0, 1'b0);

        // Source lost in the same cycle as the field sync.
        set_plan(1'b0, NPIX);
        run_frame(-1, 0, 3, 1'b0);

        for (int f = 0; f < 5; f++) begin
            set_plan(1'($urandom_range(0, 1)),
                     ($urandom_range(0, 1) == 0) ? NPIX : int'($urandom_range(0, NPIX - 1)));
            if ($urandom_range(0, 2) == 0) begin
                dr = $urandom_range(0, T_DISP_V - 1);
                run_frame(dr, $urandom_range(0, T_DISP_H - 1), $urandom_range(1, 8), 1'b0);
            end else begin
                run_frame(-2, 0, 0, 1'b0);
            end
        end

        // Starved frame followed by reset: underflow must clear.
        set_plan(1'b0, 5);
        run_frame(-2, 0, 0, 1'b0);
        repeat (2) run_frame(-2, 0, 0, 1'b0);
        tick(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
        check_eq("underflow_sticky", 32'(underflow), 32'(1));
        @(negedge pixel_clk);
        video_vs  = 1'b1;
        data_req  = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs();
        live       = 1'b0;
        run        = 0;
        exp_uf     = 1'b0;
        exp_flush  = 1'b0;
        pend_valid = 1'b0;
        prev_vs    = 1'b1;
        @(negedge pixel_clk);
        sys_rst_n = 1'b1;
        repeat (4) tick(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
